// File: rtl/bus_command_sequencer.sv
// Operator command front end: latches op/address/data from switches and buttons,
// then arbitrates for the system bus and moves the command over a narrow serial lane.
module bus_command_sequencer #(
    parameter int SW_WIDTH   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int SER_WIDTH  = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW_WIDTH-1:0]   switch1,
    input  logic                  button1,
    input  logic                  button2,
    input  logic                  button3,
    input  logic                  bus_grant,
    input  logic                  data_read_valid,
    input  logic [SER_WIDTH-1:0]  data_read,
    output logic                  bus_req,
    output logic                  bus_mode,
    output logic                  bus_valid,
    output logic [SER_WIDTH-1:0]  data_write,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LW    = ADDR_WIDTH + DATA_WIDTH;
    localparam int NCH_R = ADDR_WIDTH / SW_WIDTH;
    localparam int NCH_W = LW / SW_WIDTH;
    localparam int NB_A  = ADDR_WIDTH / SER_WIDTH;
    localparam int NB_D  = DATA_WIDTH / SER_WIDTH;
    localparam int CW    = $clog2(NCH_W + 1);
    localparam int BW    = $clog2(LW / SER_WIDTH + 1);
    localparam int IW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_REQ,
        S_ADDR, S_WDATA, S_RDATA, S_DONE
    } state_t;

    state_t                state_q;
    logic [2:0]            b1_q, b2_q, b3_q;
    logic                  op_q;
    logic [CW-1:0]         chunk_q;
    logic [BW-1:0]         beat_q;
    logic [IW-1:0]         idle_q;
    logic [LW-1:0]         ld_q, tx_q;
    logic [DATA_WIDTH-1:0] rx_q, rd_data_q;
    logic                  req_q, valid_q, done_q, err_q;
    logic [SER_WIDTH-1:0]  dw_q;

    logic                  e1_d, e2_d, e3_d, restart_d, abort_d;
    logic [CW-1:0]         chunk_d, need_d;
    logic [LW-1:0]         ld_d, tx_init_d;
    logic [DATA_WIDTH-1:0] rx_d;

    always_comb begin
        e1_d      = b1_q[1] & ~b1_q[2];
        e3_d      = b3_q[1] & ~b3_q[2] & ~e1_d;
        e2_d      = b2_q[1] & ~b2_q[2] & ~e1_d & ~e3_d;
        restart_d = e1_d && (state_q == S_IDLE || state_q == S_LOAD
                             || state_q == S_ARM);
        abort_d   = !bus_grant && (state_q == S_ADDR || state_q == S_WDATA
                                   || state_q == S_RDATA);
        chunk_d   = chunk_q + 1'b1;
        need_d    = op_q ? CW'(NCH_W) : CW'(NCH_R);
        ld_d      = (ld_q << SW_WIDTH) | LW'(switch1);
        // Reads load only the address, which then sits in the low bits.
        tx_init_d = op_q ? ld_q : (ld_q << DATA_WIDTH);
        rx_d      = (rx_q << SER_WIDTH) | DATA_WIDTH'(data_read);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            b1_q      <= '0;
            b2_q      <= '0;
            b3_q      <= '0;
            op_q      <= 1'b0;
            chunk_q   <= '0;
            beat_q    <= '0;
            idle_q    <= '0;
            ld_q      <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dw_q      <= '0;
        end else begin
            b1_q   <= {b1_q[1:0], button1};
            b2_q   <= {b2_q[1:0], button2};
            b3_q   <= {b3_q[1:0], button3};
            done_q <= 1'b0;
            if (abort_d) begin
                err_q   <= 1'b1;
                req_q   <= 1'b0;
                valid_q <= 1'b0;
                dw_q    <= '0;
                state_q <= S_IDLE;
            end else if (restart_d) begin
                op_q    <= switch1[0];
                chunk_q <= '0;
                beat_q  <= '0;
                err_q   <= 1'b0;
                state_q <= S_LOAD;
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        if (e3_d) begin
                            err_q <= 1'b1;
                        end else if (e2_d) begin
                            ld_q    <= ld_d;
                            chunk_q <= chunk_d;
                            if (chunk_d == need_d) state_q <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (e3_d) begin
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (bus_grant) begin
                            valid_q <= 1'b1;
                            dw_q    <= tx_init_d[LW-1 -: SER_WIDTH];
                            tx_q    <= tx_init_d << SER_WIDTH;
                            beat_q  <= '0;
                            state_q <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (beat_q != BW'(NB_A - 1)) begin
                            dw_q   <= tx_q[LW-1 -: SER_WIDTH];
                            tx_q   <= tx_q << SER_WIDTH;
                            beat_q <= beat_q + 1'b1;
                        end else if (op_q) begin
                            dw_q    <= tx_q[LW-1 -: SER_WIDTH];
                            tx_q    <= tx_q << SER_WIDTH;
                            beat_q  <= '0;
                            state_q <= S_WDATA;
                        end else begin
                            valid_q <= 1'b0;
                            dw_q    <= '0;
                            beat_q  <= '0;
                            idle_q  <= '0;
                            state_q <= S_RDATA;
                        end
                    end
                    S_WDATA: begin
                        if (beat_q != BW'(NB_D - 1)) begin
                            dw_q   <= tx_q[LW-1 -: SER_WIDTH];
                            tx_q   <= tx_q << SER_WIDTH;
                            beat_q <= beat_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                            dw_q    <= '0;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_RDATA: begin
                        if (data_read_valid) begin
                            rx_q   <= rx_d;
                            idle_q <= '0;
                            beat_q <= beat_q + 1'b1;
                            if (beat_q == BW'(NB_D - 1)) begin
                                rd_data_q <= rx_d;
                                req_q     <= 1'b0;
                                done_q    <= 1'b1;
                                state_q   <= S_DONE;
                            end
                        end else if (idle_q == IW'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                    // IDLE waits for button1; DONE lasts one cycle.
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus_req    = req_q;
    assign bus_mode   = op_q;
    assign bus_valid  = valid_q;
    assign data_write = dw_q;
    assign rd_data    = rd_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
endmodule
